// File: rtl/sram_arbiter.sv
// Three-port arbiter in front of a single asynchronous SRAM. Port 0 always wins;
// ports 1 and 2 alternate. Exactly one SRAM access is in flight at a time.
module sram_arbiter #(
    parameter int AW = 20,
    parameter int DW = 16
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iReq0,
    input  logic          iReq1,
    input  logic          iReq2,
    input  logic          iWe0,
    input  logic          iWe1,
    input  logic          iWe2,
    input  logic [AW-1:0] iAddr0,
    input  logic [AW-1:0] iAddr1,
    input  logic [AW-1:0] iAddr2,
    input  logic [DW-1:0] iWdata0,
    input  logic [DW-1:0] iWdata1,
    input  logic [DW-1:0] iWdata2,
    output logic          oGnt0,
    output logic          oGnt1,
    output logic          oGnt2,
    output logic          oRvalid0,
    output logic          oRvalid1,
    output logic          oRvalid2,
    output logic [DW-1:0] oRdata,
    output logic          oBusy,
    output logic [AW-1:0] oSram_addr,
    output logic          oSram_ce_n,
    output logic          oSram_oe_n,
    output logic          oSram_we_n,
    output logic          oSram_lb_n,
    output logic          oSram_ub_n,
    inout  wire  [DW-1:0] ioSram_dq
);

    typedef enum logic [1:0] {IDLE, RD, WR1, WR2} state_t;

    state_t        r_state;
    logic          r_rr;        // 0: port 1 preferred, 1: port 2 preferred
    logic [2:0]    r_gnt;
    logic [2:0]    r_rvalid;
    logic [2:0]    r_port;      // one-hot owner of the access in flight
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_oe_n;
    logic          r_we_n;
    logic          r_dq_oe;

    logic [2:0]    w_win;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    always_comb begin
        w_win = 3'b000;
        if (iReq0)
            w_win = 3'b001;
        else if (iReq1 && iReq2)
            w_win = r_rr ? 3'b100 : 3'b010;
        else if (iReq1)
            w_win = 3'b010;
        else if (iReq2)
            w_win = 3'b100;
    end

    always_comb begin
        w_we    = iWe0;
        w_addr  = iAddr0;
        w_wdata = iWdata0;
        if (w_win[1]) begin
            w_we    = iWe1;
            w_addr  = iAddr1;
            w_wdata = iWdata1;
        end else if (w_win[2]) begin
            w_we    = iWe2;
            w_addr  = iAddr2;
            w_wdata = iWdata2;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state  <= IDLE;
            r_rr     <= 1'b0;
            r_gnt    <= 3'b000;
            r_rvalid <= 3'b000;
            r_port   <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
        end else begin
            r_gnt    <= 3'b000;
            r_rvalid <= 3'b000;
            case (r_state)
                IDLE: begin
                    if (|w_win) begin
                        r_gnt   <= w_win;
                        r_port  <= w_win;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        // Pointer only moves on grants to the round-robin pair
                        if (w_win[1])
                            r_rr <= 1'b1;
                        else if (w_win[2])
                            r_rr <= 1'b0;
                        if (w_we) begin
                            r_we_n  <= 1'b0;
                            r_dq_oe <= 1'b1;
                            r_state <= WR1;
                        end else begin
                            r_oe_n  <= 1'b0;
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    r_rdata  <= ioSram_dq;
                    r_rvalid <= r_port;
                    r_oe_n   <= 1'b1;
                    r_state  <= IDLE;
                end
                WR1: begin
                    // Data stays on the bus through WR2 for SRAM hold time
                    r_we_n  <= 1'b1;
                    r_state <= WR2;
                end
                WR2: begin
                    r_dq_oe <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oGnt0      = r_gnt[0];
    assign oGnt1      = r_gnt[1];
    assign oGnt2      = r_gnt[2];
    assign oRvalid0   = r_rvalid[0];
    assign oRvalid1   = r_rvalid[1];
    assign oRvalid2   = r_rvalid[2];
    assign oRdata     = r_rdata;
    assign oBusy      = (r_state != IDLE);
    assign oSram_addr = r_addr;
    assign oSram_oe_n = r_oe_n;
    assign oSram_we_n = r_we_n;
    assign oSram_ce_n = 1'b0;
    assign oSram_lb_n = 1'b0;
    assign oSram_ub_n = 1'b0;
    assign ioSram_dq  = r_dq_oe ? r_wdata : {DW{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: async SRAM model, access-timeline reference model with a
// per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_sram_arbiter;
    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic [2:0]    req  = 3'b000;
    logic [2:0]    we   = 3'b000;
    logic [AW-1:0] addr  [3];
    logic [DW-1:0] wdata [3];

    logic          oGnt0, oGnt1, oGnt2, oRvalid0, oRvalid1, oRvalid2, oBusy;
    logic [DW-1:0] oRdata;
    logic [AW-1:0] oSram_addr;
    logic          oSram_ce_n, oSram_oe_n, oSram_we_n, oSram_lb_n, oSram_ub_n;
    tri1  [DW-1:0] ioSram_dq;   // undriven bus reads as all ones

    logic [2:0] gnt, rv;
    assign gnt = {oGnt2, oGnt1, oGnt0};
    assign rv  = {oRvalid2, oRvalid1, oRvalid0};

    sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .iClk(iClk), .iRst(iRst),
        .iReq0(req[0]), .iReq1(req[1]), .iReq2(req[2]),
        .iWe0(we[0]), .iWe1(we[1]), .iWe2(we[2]),
        .iAddr0(addr[0]), .iAddr1(addr[1]), .iAddr2(addr[2]),
        .iWdata0(wdata[0]), .iWdata1(wdata[1]), .iWdata2(wdata[2]),
        .oGnt0(oGnt0), .oGnt1(oGnt1), .oGnt2(oGnt2),
        .oRvalid0(oRvalid0), .oRvalid1(oRvalid1), .oRvalid2(oRvalid2),
        .oRdata(oRdata), .oBusy(oBusy), .oSram_addr(oSram_addr),
        .oSram_ce_n(oSram_ce_n), .oSram_oe_n(oSram_oe_n), .oSram_we_n(oSram_we_n),
        .oSram_lb_n(oSram_lb_n), .oSram_ub_n(oSram_ub_n), .ioSram_dq(ioSram_dq)
    );

    initial forever #5 iClk = ~iClk;

    // Asynchronous SRAM: drives the bus while output-enabled, stores while we_n is low
    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] mmem [DEPTH];
    bit            sram_en = 1'b0;
    assign ioSram_dq = (!oSram_ce_n && !oSram_oe_n && oSram_we_n) ? sram[oSram_addr] : {DW{1'bz}};

    initial forever begin
        @(posedge iClk);
        if (sram_en && !oSram_ce_n && !oSram_we_n) sram[oSram_addr] = ioSram_dq;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_w(input int a);
        return DW'(a * 40503 + 4660);
    endfunction

    function automatic int pick(input logic [2:0] r, input bit p2);
        if (r[0]) return 0;
        if (r[1] && r[2]) return p2 ? 2 : 1;
        if (r[1]) return 1;
        if (r[2]) return 2;
        return -1;
    endfunction

    // Reference model: the last accepted access, described by its accept cycle
    bit            mv = 1'b0;
    bit            acc_v = 1'b0;
    int            acc_s, acc_p;
    bit            acc_we;
    logic [AW-1:0] acc_a;
    logic [DW-1:0] acc_d;
    bit            pref2;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rdata;

    initial forever begin
        int m;
        @(posedge iClk);
        if (iRst) begin
            mv = 1'b1; acc_v = 1'b0; pref2 = 1'b0; e_addr = '0; e_rdata = '0;
        end else if (mv) begin
            if (acc_v && !acc_we && cyc == acc_s + 1) e_rdata = mmem[acc_a];
            if ((!acc_v || cyc >= acc_s + (acc_we ? 3 : 2)) && req != 3'b000) begin
                m = pick(req, pref2);
                acc_v = 1'b1; acc_s = cyc; acc_p = m;
                acc_we = we[m]; acc_a = addr[m]; acc_d = wdata[m];
                e_addr = acc_a;
                if (m == 1) pref2 = 1'b1;
                else if (m == 2) pref2 = 1'b0;
                if (acc_we) mmem[acc_a] = acc_d;
            end
        end
        cyc++;
    end

    logic [DW-1:0] rv2_q [$];

    initial forever begin
        logic [2:0] eg, er;
        bit rd_now;
        @(negedge iClk);
        if (mv) begin
            eg = 3'b000; er = 3'b000;
            if (acc_v && cyc == acc_s + 1) eg[acc_p] = 1'b1;
            if (acc_v && !acc_we && cyc == acc_s + 2) er[acc_p] = 1'b1;
            rd_now = acc_v && !acc_we && cyc == acc_s + 1;
            chk("gnt", gnt, eg);
            chk("rvalid", rv, er);
            chk("busy", oBusy, acc_v && cyc > acc_s && cyc < acc_s + (acc_we ? 3 : 2));
            chk("oe_n", oSram_oe_n, !rd_now);
            chk("we_n", oSram_we_n, !(acc_v && acc_we && cyc == acc_s + 1));
            chk("addr", oSram_addr, e_addr);
            chk("rdata", oRdata, e_rdata);
            chk("ties", {oSram_ce_n, oSram_lb_n, oSram_ub_n}, 3'b000);
            if (acc_v && acc_we && cyc > acc_s && cyc < acc_s + 3)
                chk("dq_write", ioSram_dq, acc_d);
            else if (!rd_now)
                chk("dq_hiz", ioSram_dq, {DW{1'b1}});
            if (oRvalid2) rv2_q.push_back(oRdata);
        end
    end

    task automatic set_req(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    endtask

    task automatic wait_gnt(output int p);
        p = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge iClk);
            if (gnt != 3'b000) begin
                p = gnt[2] ? 2 : (gnt[1] ? 1 : 0);
                return;
            end
        end
        chk("gnt_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout want finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int p, c1, c2, first, wn, g_prev;
        bit [2:0] pend;
        logic [DW-1:0] old;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i] = init_w(i);
            mmem[i] = sram[i];
        end
        sram[20'h00010] = 16'h0ABC; mmem[20'h00010] = 16'h0ABC;
        for (int i = 0; i < 4; i++) begin
            sram[20'h200 + i] = DW'(16'h1000 + i);
            mmem[20'h200 + i] = DW'(16'h1000 + i);
        end
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end

        repeat (3) @(negedge iClk);
        sram_en = 1'b1;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_rvalid", rv, 3'b000);
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_we_n", oSram_we_n, 1'b1);
        chk("rst_oe_n", oSram_oe_n, 1'b1);
        chk("rst_addr", oSram_addr, 20'h0);
        chk("rst_rdata", oRdata, 16'h0);
        chk("rst_dq", ioSram_dq, 16'hFFFF);
        iRst = 1'b0;

        // Single read on port 0
        set_req(0, 1'b0, 20'h00010, 16'h0);
        @(negedge iClk); chk("rd_gnt0", gnt, 3'b001); req[0] = 1'b0;
        @(negedge iClk); chk("rd_rvalid0", rv, 3'b001); chk("rd_data", oRdata, 16'h0ABC);

        // Single write on port 1, then read it back through port 0
        set_req(1, 1'b1, 20'h4AFFF, 16'h1234);
        wn = 0;
        @(negedge iClk); chk("wr_gnt1", gnt, 3'b010); if (!oSram_we_n) wn++; req[1] = 1'b0;
        repeat (4) begin @(negedge iClk); if (!oSram_we_n) wn++; end
        chk("wr_we_pulses", wn, 1);
        set_req(0, 1'b0, 20'h4AFFF, 16'h0);
        @(negedge iClk); req[0] = 1'b0;
        @(negedge iClk); chk("wr_readback", oRdata, 16'h1234);

        // All three held from reset: port 0 starves the rest, then 1,2,1,2
        iRst = 1'b1;
        set_req(0, 1'b0, 20'h00010, 16'h0);
        set_req(1, 1'b1, 20'h00300, 16'h5555);
        set_req(2, 1'b0, 20'h00201, 16'h0);
        @(negedge iClk); iRst = 1'b0;
        for (int k = 0; k < 5; k++) begin wait_gnt(p); chk("cont_p0", p, 0); end
        req[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin wait_gnt(p); chk("cont_rr", p, (k % 2 == 0) ? 1 : 2); end
        req = 3'b000;
        repeat (4) @(negedge iClk);

        // Round-robin between ports 1 and 2 only
        iRst = 1'b1;
        set_req(1, 1'b0, 20'h00202, 16'h0);
        set_req(2, 1'b1, 20'h00301, 16'h2222);
        @(negedge iClk); iRst = 1'b0;
        c1 = 0; c2 = 0; first = -1;
        for (int k = 0; k < 8; k++) begin
            wait_gnt(p);
            if (k == 0) first = p;
            if (p == 1) c1++;
            if (p == 2) c2++;
        end
        chk("rr_first", first, 1);
        chk("rr_count1", c1, 4);
        chk("rr_count2", c2, 4);
        req = 3'b000;
        repeat (4) @(negedge iClk);

        // Reset during WR1 aborts cleanly
        old = init_w(20'h123);
        set_req(1, 1'b1, 20'h00123, 16'h0F0F);
        @(negedge iClk); chk("rstwr_gnt1", gnt, 3'b010); req[1] = 1'b0; iRst = 1'b1;
        @(negedge iClk);
        chk("rstwr_we_n", oSram_we_n, 1'b1);
        chk("rstwr_busy", oBusy, 1'b0);
        chk("rstwr_gnt", gnt, 3'b000);
        chk("rstwr_rvalid", rv, 3'b000);
        chk("rstwr_dq", ioSram_dq, 16'hFFFF);
        iRst = 1'b0;
        set_req(0, 1'b0, 20'h00123, 16'h0);
        @(negedge iClk); req[0] = 1'b0;
        @(negedge iClk); chk("rstwr_word", (oRdata == old) || (oRdata == 16'h0F0F), 1);

        // Back-to-back reads on port 2
        rv2_q.delete();
        set_req(2, 1'b0, 20'h00200, 16'h0);
        g_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(p);
            chk("b2b_port", p, 2);
            if (i > 0) chk("b2b_gap", cyc - g_prev, 2);
            g_prev = cyc;
            if (i < 3) addr[2] = AW'(20'h200 + i + 1);
            else req[2] = 1'b0;
        end
        repeat (3) @(negedge iClk);
        chk("b2b_count", rv2_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < rv2_q.size()) chk("b2b_data", rv2_q[i], 16'h1000 + i);

        // Random traffic with occasional drops and resets
        pend = 3'b000;
        for (int n = 0; n < 4000; n++) begin
            for (int q = 0; q < 3; q++) begin
                if (gnt[q]) pend[q] = 1'b0;
                if (!pend[q]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pend[q]  = 1'b1;
                        we[q]    = (q == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                        addr[q]  = AW'($urandom_range(0, 31));
                        wdata[q] = DW'($urandom_range(0, 32'h7FFE));
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    pend[q] = 1'b0;
                end
                req[q] = pend[q];
            end
            iRst = ($urandom_range(0, 499) == 0);
            @(negedge iClk);
        end

        req = 3'b000;
        iRst = 1'b0;
        repeat (6) @(negedge iClk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, default 20, SRAM word-address width.
REQ-002 Parameter DW, default 16, SRAM data width.
REQ-003 iClk  input  1  sole clock; all state updates on its rising edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iReq0/iReq1/iReq2  input  1 each  access request: port 0 VGA read, port 1 camera write, port 2 contrast-enhancement engine.
REQ-006 iWe0/iWe1/iWe2  input  1 each  1 = write, 0 = read, qualified by the matching iReqN.
REQ-007 iAddr0/iAddr1/iAddr2  input  AW each  word address, qualified by iReqN.
REQ-008 iWdata0/iWdata1/iWdata2  input  DW each  write data, qualified by iReqN and iWeN.
REQ-009 oGnt0/oGnt1/oGnt2  output  1 each  one-cycle pulse; request accepted.
REQ-010 oRvalid0/oRvalid1/oRvalid2  output  1 each  one-cycle pulse; oRdata is valid for that port.
REQ-011 oRdata  output  DW  read data shared by all ports.
REQ-012 oBusy  output  1  high whenever state is not IDLE.
REQ-013 oSram_addr  output  AW; oSram_ce_n/oSram_oe_n/oSram_we_n/oSram_lb_n/oSram_ub_n  output  1 each; ioSram_dq  inout  DW.

Function
REQ-014 States: IDLE, RD, WR1, WR2; exactly one SRAM access in flight.
REQ-015 IDLE: if any iReqN is high, select a winner, register its addr/data/we and port id, and enter RD (iWeN=0) or WR1 (iWeN=1) next cycle; otherwise stay in IDLE.
REQ-016 Priority: port 0 beats ports 1 and 2 unconditionally.
REQ-017 Ports 1 and 2 round-robin: a 1-bit pointer selects the preferred port; after any grant to port 1 or 2, the pointer moves to the other port; port-0 grants leave it unchanged.
REQ-018 oGntN is high for exactly the first cycle of the granted access (RD or WR1); at most one oGnt is high per cycle.
REQ-019 Requester holds iReqN, iWeN, iAddrN and iWdataN stable until it sees oGntN; it may present a new request in the cycle after oGntN.
REQ-020 RD: oSram_oe_n=0, oSram_we_n=1, dq hi-Z, latched address driven; ioSram_dq is registered into oRdata at the end of RD; next state IDLE.
REQ-021 The cycle after RD, oRvalidN of the granted port is high for one cycle; oRdata holds its value until the next read completes.
REQ-022 WR1: oSram_we_n=0, oSram_oe_n=1, latched data driven on ioSram_dq; next state WR2.
REQ-023 WR2: oSram_we_n=1, address and data still driven (hold time); next state IDLE.
REQ-024 ioSram_dq is driven only in WR1 and WR2; hi-Z in all other states.
REQ-025 oSram_ce_n, oSram_lb_n and oSram_ub_n are tied to 0.
REQ-026 Latency: read = grant at T+1, oRvalid at T+2, where T is the IDLE request cycle; write completes in WR2 at T+2.
REQ-027 Throughput: one read per 2 cycles, one write per 3 cycles; requests arriving while busy wait and are arbitrated at the next IDLE.
REQ-028 Requests dropped before grant are ignored; no access is performed for them.

Reset
REQ-029 While iRst is high on a clock edge: state IDLE, pointer selects port 1, all oGnt/oRvalid 0, oBusy 0, oSram_we_n 1, oSram_oe_n 1, dq hi-Z, oRdata 0, oSram_addr 0.
REQ-030 Reset asserted mid-access (RD, WR1 or WR2) aborts the access immediately; it produces no oRvalid and no further we_n pulse.

Verification
REQ-031 Single read: iReq0, iAddr0=0x00010, SRAM model word=0x0ABC -> oGnt0 at T+1, oRvalid0 with oRdata=0x0ABC at T+2.
REQ-032 Single write: iReq1, iWe1, iAddr1=0x4AFFF, iWdata1=0x1234 -> exactly one 1-cycle we_n low pulse; readback via port 0 returns 0x1234.
REQ-033 Contention: iReq0, iReq1 and iReq2 held continuously from reset -> grant order 0,0,0,... with ports 1 and 2 starved; on release of iReq0, grants alternate 1,2,1,2.
REQ-034 Round-robin: ports 1 and 2 request continuously (port 0 idle) for 8 grants -> 4 grants each, port 1 first.
REQ-035 Reset during WR1 -> next cycle we_n=1, dq hi-Z, oBusy=0, no oGnt/oRvalid; SRAM word unchanged or fully written, never partially driven past reset.
REQ-036 Back-to-back reads on port 2 (new request the cycle after oGnt2) -> one oGnt2 every 2 cycles; oRvalid2 data matches each address in order.
